left_shift_pipe: RTL and testbench

//  Pipelined left barrel shifter: the left-direction counterpart of the right-shift stage chain.

---
 rtl/alu_shift_pkg.sv | 26 ++
 rtl/left_stage_reg.sv | 54 +++++
 rtl/left_shift_pipe.sv | 73 +++++++
 tb/tb_left_shift_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_shift_pkg.sv
// Shared types for the ALU shift pipelines: beat struct, shift-amount type, per-stage shift helper.
// The beat carries a rot bit only when ALU_ROTATE_EN is defined.
package alu_shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = $clog2(DATA_W);

    typedef logic [SHAMT_W-1:0] shamt_t;
    typedef logic [DATA_W-1:0]  data_t;

    typedef struct packed {
        logic   valid;
        data_t  data;
        shamt_t shamt;
        logic   fill;
`ifdef ALU_ROTATE_EN
        logic   rot;
`endif
    } stage_beat_t;

    // Stage 0 takes the largest step so the MSB of shamt is consumed first.
    function automatic int stage_amt(input int k);
        return 1 << (SHAMT_W - 1 - k);
    endfunction

endpackage

// File: rtl/left_stage_reg.sv
// One registered left-shift stage by S, enabled by shamt[BIT]; 1 cycle, loads when empty or downstream advances.
// With ALU_ROTATE_EN the vacated LSBs take the bits shifted out instead of fill when rot=1.
module left_stage_reg
    import alu_shift_pkg::*;
#(
    parameter int S   = 1,
    parameter int BIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  stage_beat_t beat_i,
    input  logic        adv_i,
    output logic        load_o,
    output stage_beat_t beat_o
);

    stage_beat_t beat_d;
    stage_beat_t beat_q;
    data_t       shifted;
    logic [S-1:0] fill_bits;

    always_comb begin
        fill_bits = {S{beat_i.fill}};
`ifdef ALU_ROTATE_EN
        if (beat_i.rot) begin
            fill_bits = beat_i.data[DATA_W-1 -: S];
        end
`endif
        shifted = beat_i.data;
        if (beat_i.shamt[BIT]) begin
            shifted = {beat_i.data[DATA_W-1-S:0], fill_bits};
        end

        load_o = !beat_q.valid || adv_i;

        // Data updates even for bubbles; the valid bit is what matters downstream.
        beat_d = beat_q;
        if (load_o) begin
            beat_d      = beat_i;
            beat_d.data = shifted;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat_o = beat_q;

endmodule

// File: rtl/left_shift_pipe.sv
// Pipelined left barrel shifter, SHAMT_W registered stages (latency SHAMT_W), full valid/ready backpressure.
// ALU_ROTATE_EN enables rotate-left via in_rot; otherwise in_rot is ignored.
module left_shift_pipe
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_fill,
    input  logic               in_rot,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    stage_beat_t beat [SHAMT_W+1];
    logic        load [SHAMT_W];
    logic        adv  [SHAMT_W];

    always_comb begin
        beat[0]       = '0;
        beat[0].valid = in_valid;
        beat[0].data  = in_data;
        beat[0].shamt = in_shamt;
        beat[0].fill  = in_fill;
`ifdef ALU_ROTATE_EN
        beat[0].rot   = in_rot;
`endif
    end

`ifndef ALU_ROTATE_EN
    logic unused_rot;
    assign unused_rot = in_rot;
`endif

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        // Ready ripples back from the output: a stage loads if empty or its successor loads.
        if (k == SHAMT_W - 1) begin : g_last
            assign adv[k] = out_ready;
        end else begin : g_mid
            assign adv[k] = load[k+1];
        end

        left_stage_reg #(
            .S   (stage_amt(k)),
            .BIT (SHAMT_W - 1 - k)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .beat_i (beat[k]),
            .adv_i  (adv[k]),
            .load_o (load[k]),
            .beat_o (beat[k+1])
        );
    end

    assign in_ready  = load[0];
    assign out_valid = beat[SHAMT_W].valid;
    assign out_data  = beat[SHAMT_W].data;

    logic unused_tail;
`ifdef ALU_ROTATE_EN
    assign unused_tail = ^{beat[SHAMT_W].shamt, beat[SHAMT_W].fill, beat[SHAMT_W].rot};
`else
    assign unused_tail = ^{beat[SHAMT_W].shamt, beat[SHAMT_W].fill};
`endif

endmodule

// File: tb/tb_left_shift_pipe.sv
// Randomized scoreboard bench for left_shift_pipe against an arithmetic shift/rotate model.
module tb_left_shift_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        in_fill;
    logic        in_rot;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    logic [31:0] exp_q[$];
    logic        held_vld = 1'b0;
    logic [31:0] held_dat = '0;

    left_shift_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_fill   (in_fill),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh,
                                          input logic f, input logic r);
        logic [63:0] w;
        logic [63:0] mask;
        w    = {32'd0, d} << sh;
        mask = (64'd1 << sh) - 64'd1;
`ifdef ALU_ROTATE_EN
        if (r) return w[31:0] | w[63:32];
`else
        if (r) begin end
`endif
        return w[31:0] | (f ? mask[31:0] : 32'd0);
    endfunction

    // Compare process: inputs are driven at negedge, so #1 later every handshake for the next posedge is settled.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", out_data, 32'd0);
            exp_q.delete();
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", out_data, held_dat);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
                pops++;
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_data, in_shamt, in_fill, in_rot));
            held_vld = out_valid && !out_ready;
            held_dat = out_data;
        end
    end

    task automatic set_in(input logic v, input logic [31:0] d, input logic [4:0] sh,
                          input logic f, input logic r);
        in_valid = v;
        in_data  = d;
        in_shamt = sh;
        in_fill  = f;
        in_rot   = r;
    endtask

    task automatic single(input string name, input logic [31:0] d, input logic [4:0] sh,
                          input logic f, input logic r, input logic [31:0] exp, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        set_in(1'b1, d, sh, f, r);
        #2;
        chk({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        lat = 1;
        #2;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            #2;
        end
        chk({name, "_data"}, out_data, exp);
    endtask

    initial begin
        int lat;
        int acc;
        int p0;
        int cyc;
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);

        // Hand-computed expectations pin the model as well as the DUT.
        single("t1", 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, lat);
        chk("t1_latency", lat, 32'd5);
        chk("model_pin1", model(32'h1234_5678, 5'd4, 1'b1, 1'b0), 32'h2345_678F);
        single("t2a", 32'h1234_5678, 5'd4, 1'b1, 1'b0, 32'h2345_678F, lat);
        single("t2b", 32'h1234_5678, 5'd0, 1'b1, 1'b0, 32'h1234_5678, lat);
        single("t2c", 32'hFFFF_FFFF, 5'd16, 1'b0, 1'b1, 32'hFFFF_0000
`ifdef ALU_ROTATE_EN
               | 32'h0000_FFFF
`endif
               , lat);
        repeat (3) @(negedge clk);

        // Back-to-back stream must sustain one result per cycle.
        p0 = pops;
        acc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            set_in(1'b1, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
            #2;
            if (in_ready) acc++;
        end
        @(negedge clk);
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        chk("t3_accepts", acc, 32'd100);
        chk("t3_throughput", pops - p0, 32'd100);

        // Fill from empty with the output stalled: exactly one beat per stage gets in.
        @(negedge clk);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            set_in(1'b1, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
            #2;
            if (in_ready) acc++;
        end
        chk("t4_accepts", acc, 32'd5);
        chk("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        chk("t4_drained", exp_q.size(), 32'd0);

        // Random handshakes on both sides.
        p0 = pops;
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            set_in($urandom_range(0, 3) != 0, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
            #2;
            if (in_valid && in_ready) acc++;
        end
        @(negedge clk);
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        cyc = 0;
        #2;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            #2;
        end
        repeat (2) @(negedge clk);
        chk("t5_accepts", acc, 32'd1000);
        chk("t5_delivered", pops - p0, 32'd1000);
        chk("t5_queue_empty", exp_q.size(), 32'd0);

        // Reset with beats still in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            set_in(1'b1, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
        end
        @(negedge clk);
        set_in(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_inflight", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        #2;
        chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            chk("t6_no_stale", {31'd0, out_valid}, 32'd0);
        end

`ifdef ALU_ROTATE_EN
        single("t7_rot", 32'h8000_0001, 5'd1, 1'b0, 1'b1, 32'h0000_0003, lat);
        repeat (3) @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
